instr_fetch_unit: RTL and testbench

//   Initiator side of the instruction-memory read port: owns the PC, drives chip-select/read/address

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned STATE_W          = 2;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } ifu_state_e;

    function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the instruction memory and
// hands one instruction at a time to decode through a valid/ready register.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               im_cs,
    output logic               im_wr,
    output logic               im_rd,
    output logic [31:0]        im_addr,
    input  logic [INSTR_W-1:0] im_data,
    output logic [INSTR_W-1:0] ir,
    output logic [31:0]        ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    import ifu_pkg::*;

    ifu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic [31:0]         fetch_count_q, fetch_count_d;

    logic redirect_bad;
    logic slot_free;
    logic capture;

    assign redirect_bad = redirect_valid && !is_word_aligned(redirect_pc);
    assign slot_free    = !ir_valid_q || ir_ready;
    // Memory is only read while selected, so capture never sees undriven data.
    assign capture      = (state_q == ST_RUN) && slot_free && !halt && !redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a misaligned target is fatal from any live state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_bad) begin
                    state_d = ST_FAULT;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_bad) begin
                    state_d = ST_FAULT;
                end else if (halt) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory-port and status outputs decoded from the state register.
    always_comb begin
        im_cs = 1'b0;
        im_rd = 1'b0;
        fault = 1'b0;
        if (state_q == ST_RUN) begin
            im_cs = 1'b1;
            im_rd = 1'b1;
        end
        if (state_q == ST_FAULT) begin
            fault = 1'b1;
        end
    end

    assign im_wr       = 1'b0;
    assign im_addr     = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign fetch_count = fetch_count_q;

    // PC and instruction register update, redirect first, then capture, then drain.
    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;
        if (state_q == ST_FAULT) begin
            ir_valid_d = 1'b0;
        end else if (redirect_valid) begin
            ir_valid_d = 1'b0;
            if (!redirect_bad) begin
                pc_d = redirect_pc;
            end
        end else if (capture) begin
            ir_d          = im_data;
            ir_pc_d       = pc_q;
            ir_valid_d    = 1'b1;
            pc_d          = pc_q + PC_INC;
            fetch_count_d = fetch_count_q + 32'd1;
        end else if (ir_ready && ir_valid_q) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= INSTR_W'(0);
            ir_pc_q       <= 32'd0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences for
// wrap/reset/halt corners, then random traffic against a behavioural model.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, halt, redirect_valid, ir_ready;
    logic [31:0] redirect_pc;
    logic        im_cs, im_wr, im_rd, ir_valid, fault;
    logic [31:0] im_addr, im_data, ir, ir_pc, fetch_count;

    logic        start_w, tie0;
    logic [31:0] tie0_w;
    logic        im_cs_w, im_wr_w, im_rd_w, ir_valid_w, fault_w;
    logic [31:0] im_addr_w, im_data_w, ir_w, ir_pc_w, fetch_count_w;

    logic [7:0] mem [4096];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_cs(im_cs), .im_wr(im_wr), .im_rd(im_rd), .im_addr(im_addr),
        .im_data(im_data), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .fault(fault), .fetch_count(fetch_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .INSTR_W(32)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .halt(tie0),
        .redirect_valid(tie0), .redirect_pc(tie0_w),
        .im_cs(im_cs_w), .im_wr(im_wr_w), .im_rd(im_rd_w), .im_addr(im_addr_w),
        .im_data(im_data_w), .ir(ir_w), .ir_pc(ir_pc_w), .ir_valid(ir_valid_w),
        .ir_ready(ir_ready), .fault(fault_w), .fetch_count(fetch_count_w)
    );

    // Big-endian byte memory aliased on [11:0]; poison value when deselected.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {mem[b], mem[b + 12'd1], mem[b + 12'd2], mem[b + 12'd3]};
    endfunction

    assign im_data   = (im_cs && im_rd)     ? word_at(im_addr)   : 32'hDEAD_BEEF;
    assign im_data_w = (im_cs_w && im_rd_w) ? word_at(im_addr_w) : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic h,
                         input logic rv, input logic [31:0] rpc, input logic rdy);
        reset = r; start = s; halt = h;
        redirect_valid = rv; redirect_pc = rpc; ir_ready = rdy;
    endtask

    task automatic chk_all(input string tag, input logic cs, input logic v, input logic f,
                           input logic [31:0] addr, input logic [31:0] ipc,
                           input logic [31:0] iw, input logic [31:0] fc);
        chk({tag, ".im_cs"}, 32'(im_cs), 32'(cs));
        chk({tag, ".im_rd"}, 32'(im_rd), 32'(cs));
        chk({tag, ".im_wr"}, 32'(im_wr), 32'd0);
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(v));
        chk({tag, ".fault"}, 32'(fault), 32'(f));
        chk({tag, ".im_addr"}, im_addr, addr);
        chk({tag, ".ir_pc"}, ir_pc, ipc);
        chk({tag, ".ir"}, ir, iw);
        chk({tag, ".fetch_count"}, fetch_count, fc);
    endtask

    typedef struct {
        logic        rst, st, hl, rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_cs, e_v, e_f;
        logic [31:0] e_addr, e_pc, e_ir, e_fc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic hl, input logic rv,
                                input logic [31:0] rpc, input logic rdy,
                                input logic e_cs, input logic e_v, input logic e_f,
                                input logic [31:0] e_addr, input logic [31:0] e_pc,
                                input logic [31:0] e_ir, input logic [31:0] e_fc);
        vec_t t;
        t.rst = rst; t.st = st; t.hl = hl; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.e_cs = e_cs; t.e_v = e_v; t.e_f = e_f;
        t.e_addr = e_addr; t.e_pc = e_pc; t.e_ir = e_ir; t.e_fc = e_fc;
        return t;
    endfunction

    // Behavioural reference: plain variables updated by the fetch rules.
    logic        m_run, m_fault, m_v;
    logic [31:0] m_pc, m_ir, m_irpc, m_fc;

    task automatic model_step(input logic r, input logic s, input logic h,
                              input logic rv, input logic [31:0] rpc, input logic rdy);
        logic bad, was_run;
        if (r) begin
            m_run = 0; m_fault = 0; m_v = 0;
            m_pc = 32'h0; m_ir = 0; m_irpc = 0; m_fc = 0;
        end else begin
            bad     = rv && (rpc[1:0] != 2'b00);
            was_run = m_run;
            if (m_fault) begin
                m_v = 0;
            end else if (rv) begin
                m_v = 0;
                if (!bad) m_pc = rpc;
            end else if (was_run && !h && (!m_v || rdy)) begin
                m_ir = word_at(m_pc); m_irpc = m_pc; m_v = 1;
                m_pc = m_pc + 32'd4; m_fc = m_fc + 32'd1;
            end else if (rdy) begin
                m_v = 0;
            end
            if (!m_fault) begin
                if (bad) begin
                    m_fault = 1; m_run = 0;
                end else if (!was_run && s) begin
                    m_run = 1;
                end else if (was_run && h) begin
                    m_run = 0;
                end
            end
        end
    endtask

    vec_t tbl[20];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) & 255);
        for (int i = 0; i < 4; i++) begin
            mem[i]      = 8'h11;
            mem[4 + i]  = 8'h22;
            mem[8 + i]  = 8'h33;
            mem[12 + i] = 8'h44;
        end
        mem[12'h100] = 8'hAA; mem[12'h101] = 8'hBB; mem[12'h102] = 8'hCC; mem[12'h103] = 8'hDD;
        mem[12'hFFC] = 8'h9A; mem[12'hFFD] = 8'hBC; mem[12'hFFE] = 8'hDE; mem[12'hFFF] = 8'hF0;

        tie0 = 1'b0; tie0_w = 32'd0; start_w = 1'b0;

        //             rst st hl rv rpc        rdy  cs v  f  addr        ir_pc       ir            fc
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,   0,   0, 0, 0, 32'h0,   32'h0,   32'h0,        0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h0,   1,   1, 0, 0, 32'h0,   32'h0,   32'h0,        0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'h4,   32'h0,   32'h11111111, 1);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'h8,   32'h4,   32'h22222222, 2);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'hC,   32'h8,   32'h33333333, 3);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'h10,  32'hC,   32'h44444444, 4);
        tbl[6]  = mk(0, 0, 1, 0, 32'h0,   1,   0, 0, 0, 32'h10,  32'hC,   32'h44444444, 4);
        tbl[7]  = mk(1, 0, 0, 0, 32'h0,   0,   0, 0, 0, 32'h0,   32'h0,   32'h0,        0);
        tbl[8]  = mk(0, 1, 0, 0, 32'h0,   1,   1, 0, 0, 32'h0,   32'h0,   32'h0,        0);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'h4,   32'h0,   32'h11111111, 1);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'h8,   32'h4,   32'h22222222, 2);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,   0,   1, 1, 0, 32'h8,   32'h4,   32'h22222222, 2);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,   0,   1, 1, 0, 32'h8,   32'h4,   32'h22222222, 2);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,   0,   1, 1, 0, 32'h8,   32'h4,   32'h22222222, 2);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'hC,   32'h8,   32'h33333333, 3);
        tbl[15] = mk(0, 0, 0, 1, 32'h100, 0,   1, 0, 0, 32'h100, 32'h8,   32'h33333333, 3);
        tbl[16] = mk(0, 0, 0, 0, 32'h0,   1,   1, 1, 0, 32'h104, 32'h100, 32'hAABBCCDD, 4);
        tbl[17] = mk(0, 0, 0, 1, 32'h102, 0,   0, 0, 1, 32'h104, 32'h100, 32'hAABBCCDD, 4);
        tbl[18] = mk(0, 1, 0, 0, 32'h0,   0,   0, 0, 1, 32'h104, 32'h100, 32'hAABBCCDD, 4);
        tbl[19] = mk(1, 0, 0, 0, 32'h0,   0,   0, 0, 0, 32'h0,   32'h0,   32'h0,        0);

        drive(1, 0, 0, 0, 32'h0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].hl, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_cs, tbl[i].e_v, tbl[i].e_f,
                    tbl[i].e_addr, tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_fc);
        end

        // PC wrap from 0xFFFF_FFFC to 0 on the second instance.
        chk("wrap.reset_addr", im_addr_w, 32'hFFFF_FFFC);
        chk("wrap.reset_cs", 32'(im_cs_w), 32'd0);
        drive(0, 0, 0, 0, 32'h0, 1);
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        chk("wrap.run_cs", 32'(im_cs_w), 32'd1);
        chk("wrap.run_valid", 32'(ir_valid_w), 32'd0);
        step();
        chk("wrap.first_valid", 32'(ir_valid_w), 32'd1);
        chk("wrap.first_pc", ir_pc_w, 32'hFFFF_FFFC);
        chk("wrap.first_ir", ir_w, 32'h9ABCDEF0);
        chk("wrap.first_addr", im_addr_w, 32'h0);
        step();
        chk("wrap.second_pc", ir_pc_w, 32'h0);
        chk("wrap.second_ir", ir_w, 32'h11111111);
        chk("wrap.second_addr", im_addr_w, 32'h4);
        chk("wrap.count", fetch_count_w, 32'd2);
        chk("wrap.rd", 32'(im_rd_w), 32'd1);
        chk("wrap.wr", 32'(im_wr_w), 32'd0);
        chk("wrap.fault", 32'(fault_w), 32'd0);

        // Reset mid-RUN with a valid instruction held.
        drive(1, 0, 0, 0, 32'h0, 1); step();
        drive(0, 1, 0, 0, 32'h0, 1); step();
        drive(0, 0, 0, 0, 32'h0, 1); step();
        chk("midrst.pre_valid", 32'(ir_valid), 32'd1);
        drive(1, 0, 0, 0, 32'h0, 1); step();
        chk_all("midrst", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

        // Halt in RUN while decode stalls; held instruction drains afterwards.
        drive(0, 1, 0, 0, 32'h0, 0); step();
        drive(0, 0, 0, 0, 32'h0, 0); step();
        chk_all("halt.fill", 1, 1, 0, 32'h4, 32'h0, 32'h11111111, 1);
        drive(0, 0, 1, 0, 32'h0, 0); step();
        chk_all("halt.stop", 0, 1, 0, 32'h4, 32'h0, 32'h11111111, 1);
        drive(0, 0, 0, 0, 32'h0, 1); step();
        chk_all("halt.drain", 0, 0, 0, 32'h4, 32'h0, 32'h11111111, 1);

        // Random traffic against the reference model.
        drive(1, 0, 0, 0, 32'h0, 0);
        model_step(1, 0, 0, 0, 32'h0, 0);
        step();
        for (int c = 0; c < 3000; c++) begin
            logic r, s, h, rv, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 15) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rpc = {$urandom()} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 39) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            drive(r, s, h, rv, rpc, rdy);
            model_step(r, s, h, rv, rpc, rdy);
            step();
            chk_all($sformatf("rnd%0d", c), m_run && !m_fault, m_v, m_fault,
                    m_pc, m_irpc, m_ir, m_fc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
